openila_capture: RTL and testbench

- Capture controller and sample store on the consuming end of the trigger interface.
- Records one sample per clock into a circular buffer while armed, then accepts the single-cycle combinational trigger. It keeps a programmable number of post-trigger samples and stops.
- Streams the capture out oldest-first over a valid/ready read port for the debug-transport layer.

---
 rtl/openila_capture.sv | 145 ++++++++++++++
 tb/tb_openila_capture.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/openila_capture.sv
// rtl/openila_capture.sv - ILA capture controller: circular sample store, trigger/post-count, oldest-first readout.
// Optional macro OPENILA_CAPTURE_TRIG_INDEX_EN adds trig_index/trig_lost outputs.
module openila_capture #(
  parameter int W_DATA = 8,
  parameter int DEPTH  = 256,
  localparam int W_ADDR = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] sample,
  input  logic              trigger,
  input  logic              arm,
  input  logic              abort,
  input  logic [W_ADDR-1:0] post_count,
  output logic              armed,
  output logic              capturing,
  output logic              done,
  output logic [W_DATA-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
  ,
  output logic [W_ADDR-1:0] trig_index,
  output logic              trig_lost
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  logic [1:0]        state;
  logic [W_ADDR-1:0] wr_ptr;
  logic              wrapped;
  logic [W_ADDR-1:0] post_cnt;
  logic [W_ADDR:0]   rd_cnt;
  logic [W_DATA-1:0] mem [DEPTH];

  logic              writing;
  logic [W_ADDR:0]   n_len;
  logic [W_ADDR-1:0] start_addr;
  logic [W_ADDR-1:0] rd_addr;
  logic              xfer;
  logic              load;

  assign writing    = !abort && (state == S_ARMED || state == S_POST);
  assign n_len      = wrapped ? (W_ADDR+1)'(DEPTH) : {1'b0, wr_ptr};
  assign start_addr = wrapped ? wr_ptr : '0;
  assign rd_addr    = start_addr + rd_cnt[W_ADDR-1:0];
  assign xfer       = rd_valid && rd_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load       = (state == S_READ) && (!rd_valid || rd_ready) && (rd_cnt != n_len);

  assign armed     = (state == S_ARMED);
  assign capturing = (state == S_POST);
  assign done      = (state == S_READ);

  always_ff @(posedge clk) begin
    if (writing) mem[wr_ptr] <= sample;
  end

`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
  logic [W_ADDR-1:0] trig_ptr;
  logic              lost_q;
  assign trig_index = done ? (trig_ptr - start_addr) : '0;
  assign trig_lost  = done && lost_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      wrapped  <= 1'b0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
      trig_ptr <= '0;
      lost_q   <= 1'b0;
`endif
    end else if (abort) begin
      state    <= S_IDLE;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (writing) begin
        wr_ptr <= wr_ptr + W_ADDR'(1);
        if (wr_ptr == W_ADDR'(DEPTH - 1)) wrapped <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (arm) begin
            state   <= S_ARMED;
            wr_ptr  <= '0;
            wrapped <= 1'b0;
            rd_cnt  <= '0;
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
            lost_q  <= 1'b0;
`endif
          end
        end
        S_ARMED: begin
          if (trigger) begin
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
            trig_ptr <= wr_ptr;
`endif
            if (post_count == '0) begin
              state <= S_READ;
            end else begin
              post_cnt <= post_count;
              state    <= S_POST;
            end
          end
        end
        S_POST: begin
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
          if (wr_ptr == trig_ptr) lost_q <= 1'b1;
`endif
          post_cnt <= post_cnt - W_ADDR'(1);
          if (post_cnt == W_ADDR'(1)) state <= S_READ;
        end
        default: begin
          if (load) begin
            rd_data  <= mem[rd_addr];
            rd_last  <= (rd_cnt == n_len - (W_ADDR+1)'(1));
            rd_valid <= 1'b1;
            rd_cnt   <= rd_cnt + (W_ADDR+1)'(1);
          end else if (xfer) begin
            rd_valid <= 1'b0;
          end
          if (xfer && rd_last) begin
            state    <= S_IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_openila_capture.sv
// tb/tb_openila_capture.sv - directed scoreboard bench for openila_capture at DEPTH=16.
module tb_openila_capture;
  localparam int W_DATA = 8;
  localparam int DEPTH  = 16;
  localparam int W_ADDR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [W_DATA-1:0] sample = '0;
  logic              trigger = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic [W_ADDR-1:0] post_count = '0;
  logic              armed, capturing, done;
  logic [W_DATA-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              rd_last;
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
  logic [W_ADDR-1:0] trig_index;
  logic              trig_lost;
`endif

  openila_capture #(.W_DATA(W_DATA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .trigger(trigger), .arm(arm),
    .abort(abort), .post_count(post_count), .armed(armed), .capturing(capturing),
    .done(done), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last)
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
    , .trig_index(trig_index), .trig_lost(trig_lost)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W_DATA-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_capturing"}, capturing, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  // abort_post: abort on that many cycles into POST; abort_read: abort after that many transfers.
  task automatic run_capture(input int trig_at, input int post, input bit rand_ready,
                             input int abort_post, input int abort_read, input bit poke_arm);
    int total, n, xfers, budget;
    bit fin;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    chk("armed_after_arm", armed, 1);
    for (int k = 0; k <= trig_at + post; k++) begin
      sample     = k[W_DATA-1:0];
      trigger    = (k == trig_at);
      post_count = (k == trig_at) ? post[W_ADDR-1:0] : W_ADDR'($urandom_range(0, 15));
      arm        = poke_arm && (k == trig_at + 1);
      if (abort_post > 0 && k == trig_at + abort_post) begin
        chk("capturing_before_abort", capturing, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; trigger = 1'b0; arm = 1'b0;
        check_idle("abort_post");
        return;
      end
      @(negedge clk);
    end
    trigger = 1'b0; arm = 1'b0;
    chk("done_after_capture", done, 1);
    total = trig_at + 1 + post;
    n = (total > DEPTH) ? DEPTH : total;
    for (int i = total - n; i < total; i++) exp_q.push_back(i[W_DATA-1:0]);
`ifdef OPENILA_CAPTURE_TRIG_INDEX_EN
    chk("trig_index", trig_index, trig_at - (total - n));
    chk("trig_lost", trig_lost, 0);
`endif
    xfers = 0; fin = 1'b0; budget = 0;
    while (!fin && budget < 200) begin
      budget++;
      arm = poke_arm && (budget == 2);
      if (abort_read > 0 && xfers == abort_read) begin
        rd_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; arm = 1'b0;
        check_idle("abort_read");
        exp_q.delete();
        return;
      end
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid) begin
        chk("rd_data", rd_data, exp_q[0]);
        chk("rd_last", rd_last, exp_q.size() == 1);
        if (rd_ready) begin
          void'(exp_q.pop_front());
          xfers++;
          if (exp_q.size() == 0) fin = 1'b1;
        end
      end
      @(negedge clk);
    end
    rd_ready = 1'b0; arm = 1'b0;
    chk("read_complete", fin, 1);
    chk("xfer_count", xfers, n);
    check_idle("after_read");
    exp_q.delete();
  endtask

  initial begin
    #12;
    check_idle("reset");
    chk("reset_rd_last", rd_last, 0);
    chk("reset_rd_data", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;

    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("idle_trigger");
    end
    trigger = 1'b0;

    run_capture(32'h20, 3, 1'b0, 0, 0, 1'b0);
    run_capture(0, 0, 1'b0, 0, 0, 1'b0);
    run_capture(5, 2, 1'b0, 0, 0, 1'b0);
    run_capture(32'h20, 3, 1'b1, 0, 0, 1'b0);
    run_capture(32'h20, 3, 1'b0, 2, 0, 1'b0);
    run_capture(32'h20, 3, 1'b0, 0, 0, 1'b0);
    run_capture(32'h20, 3, 1'b1, 0, 5, 1'b0);
    run_capture(32'h20, 3, 1'b0, 0, 0, 1'b0);
    run_capture(32'h20, 3, 1'b1, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
